// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: default width, FSM encodings
// and the parity helper used at frame accept.
package uart_tx_pkg;

  localparam int unsigned TX_WIDTH_DEF = 8;
  localparam int unsigned PAR_MAX_W    = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Even parity when odd = 0, odd parity when odd = 1; callers zero-extend data.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Load/shift-right register plus bit counter feeding the UART transmit line.
// ser_data is the bit that the top registers onto the line at the next edge.
module tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = TX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ser_en,
  input  logic [WIDTH-1:0] p_data,
  output logic             ser_data,
  output logic             ser_done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for shift register and counter. The counter is parked at
  // all-ones on load so the shift that launches bit 0 wraps it to 0, making
  // cnt_q equal the index of the bit currently on the line.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = p_data;
      cnt_d   = {CNT_W{1'b1}};
    end else if (ser_en) begin
      shift_d = shift_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_data = shift_q[0];
  assign ser_done = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmit FSM: start bit, WIDTH data bits LSB first, optional parity,
// stop bit. One bit per clk; tx_out and busy are driven straight from flops.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = TX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_data,
  input  logic             data_valid,
  input  logic             par_en,
  input  logic             par_typ,
  output logic             tx_out,
  output logic             busy
);

  logic [2:0] state_q, state_d;
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic       tx_out_q, tx_out_d;
  logic       busy_q, busy_d;
  logic       load, ser_en, ser_data, ser_done;

  assign load   = (state_q == S_IDLE) && data_valid;
  // The serializer shifts whenever the next line bit is a data bit.
  assign ser_en = (state_d == S_DATA);

  tx_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .ser_en   (ser_en),
    .p_data   (p_data),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  // Frame sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = data_valid ? S_START : S_IDLE;
      S_START:  state_d = S_DATA;
      S_DATA: begin
        if (ser_done) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Parity options are frozen at accept so mid-frame input changes are inert.
  always_comb begin
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (load) begin
      par_en_d  = par_en;
      par_bit_d = parity_bit(PAR_MAX_W'(p_data), par_typ);
    end else begin
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_out_d = 1'b1;
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = ser_data;
      S_PARITY: tx_out_d = par_bit_q;
      S_STOP:   tx_out_d = 1'b1;
      default:  tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at WIDTH = 8 with hand-written expected frames.
module tb_uart_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         tx_out;
  logic         busy;

  int total = 0;
  int bad   = 0;

  uart_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, {31'd0, tx_out}, 32'd1);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic request(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
  endtask

  // seq holds the n line bits in time order, first bit in seq[n-1].
  task automatic watch_frame(input string tag, input logic [10:0] seq, input int n,
                             input bit keep_valid, input int disturb_at);
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1 && !keep_valid) data_valid = 1'b0;
      check($sformatf("%s tx c%0d", tag, k), {31'd0, tx_out}, {31'd0, seq[n-k]});
      check($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, 32'd1);
      if (k == disturb_at) begin
        p_data     = 8'h00;
        par_en     = ~par_en;
        par_typ    = ~par_typ;
        data_valid = 1'b1;
      end else if (k == disturb_at + 1) begin
        data_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle({tag, " gap"});
  endtask

  initial begin
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    request(8'hA5, 1'b0, 1'b0);
    watch_frame("a5_nopar", 11'b0_0101001011, 10, 1'b0, -1);
    request(8'hA5, 1'b1, 1'b0);
    watch_frame("a5_even", 11'b01010010101, 11, 1'b0, -1);
    request(8'hA5, 1'b1, 1'b1);
    watch_frame("a5_odd", 11'b01010010111, 11, 1'b0, -1);
    request(8'h01, 1'b1, 1'b0);
    watch_frame("01_even", 11'b01000000011, 11, 1'b0, -1);

    // Held request: two frames separated by exactly one idle cycle.
    request(8'hFF, 1'b0, 1'b0);
    watch_frame("ff_hold1", 11'b0_0111111111, 10, 1'b1, -1);
    watch_frame("ff_hold2", 11'b0_0111111111, 10, 1'b1, -1);
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("ff_after%0d", i));
    end

    // Inputs disturbed during DATA must not alter or follow the frame.
    request(8'hA5, 1'b0, 1'b0);
    watch_frame("mid_change", 11'b0_0101001011, 10, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("mid_after%0d", i));
    end

    // Reset while data bit 3 is on the line.
    request(8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) data_valid = 1'b0;
    end
    check("rst_bit3 tx", {31'd0, tx_out}, 32'd0);
    check("rst_bit3 busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1 check_idle("rst_abort");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("rst_after%0d", i));
    end
    request(8'h01, 1'b1, 1'b0);
    watch_frame("recover", 11'b01000000011, 11, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
